// File: rtl/bless_inject_ctrl_pkg.sv
// Shared widths, defaults, FSM type and helpers for the BLESS local-injection scheduler.
package bless_inject_ctrl_pkg;

    // Router port widths (network ports and local/NI port).
    localparam int WIDTH_PORT           = 16;
    localparam int WIDTH_PORT_NI        = 16;

    // Block defaults.
    localparam int STARVE_LIMIT_DEFAULT = 16;
    localparam int INJ_FIFO_DEPTH       = 4;

    // Width of the blocked-cycle counter; STARVE_LIMIT is at most 255.
    localparam int BLK_CNT_W            = 8;

    // Starvation FSM: IDLE = no head, WAIT = head present, STARVED = head blocked too long.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_STARVED = 2'd2
    } starve_state_t;

    // Number of occupied network inputs; a port is occupied when its flit is nonzero.
    function automatic logic [2:0] busy_ports(
        input logic [WIDTH_PORT-1:0] w,
        input logic [WIDTH_PORT-1:0] e,
        input logic [WIDTH_PORT-1:0] s,
        input logic [WIDTH_PORT-1:0] n
    );
        logic [2:0] cnt;
        cnt = 3'd0;
        if (w != '0) cnt = cnt + 3'd1;
        if (e != '0) cnt = cnt + 3'd1;
        if (s != '0) cnt = cnt + 3'd1;
        if (n != '0) cnt = cnt + 3'd1;
        return cnt;
    endfunction

endpackage

// File: rtl/bless_inject_ctrl_inj_fifo.sv
// Small synchronous FIFO holding core flits awaiting injection; full/empty derive from count.
module inj_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // Push is refused when full even if a pop happens the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset because head is only consumed when count > 0.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bless_inject_ctrl.sv
// Local-injection scheduler for the bufferless BLESS router: injects the queued head flit
// only when a network input is empty, and flags starvation of the head for throttling.
module bless_inject_ctrl
    import bless_inject_ctrl_pkg::*;
#(
    parameter int DEPTH        = INJ_FIFO_DEPTH,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH_PORT_NI-1:0]  coreFlit,
    input  logic                      coreValid,
    output logic                      coreReady,
    input  logic [WIDTH_PORT-1:0]     dinW,
    input  logic [WIDTH_PORT-1:0]     dinE,
    input  logic [WIDTH_PORT-1:0]     dinS,
    input  logic [WIDTH_PORT-1:0]     dinN,
    output logic [WIDTH_PORT_NI-1:0]  injFlit,
    output logic                      starve,
    output logic [$clog2(DEPTH):0]    fifoCount,
    output logic [15:0]               injCount,
    output starve_state_t             fsm_state
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [BLK_CNT_W-1:0] LIMIT = BLK_CNT_W'(STARVE_LIMIT);

    // Handshake: a flit transfers at a posedge where coreValid && coreReady. coreReady is
    // !full from registered state only, so it never depends on coreValid or din* this cycle.
    // All-zero flits complete the handshake but are dropped, since zero means "empty" downstream.

    starve_state_t              state;
    starve_state_t              state_next;
    logic [BLK_CNT_W-1:0]       blk_cnt;
    logic [BLK_CNT_W-1:0]       blk_next;
    logic [WIDTH_PORT_NI-1:0]   head;
    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       free_slot;
    logic                       inj;
    logic [CW-1:0]              count_next;

    assign coreReady = !full;
    assign push      = coreValid && coreReady && (coreFlit != '0);
    // A free output exists whenever fewer than four network inputs carry a flit.
    assign free_slot = (busy_ports(dinW, dinE, dinS, dinN) < 3'd4);
    assign inj       = !empty && free_slot;
    assign injFlit   = inj ? head : '0;
    assign starve    = (state == ST_STARVED);
    assign fsm_state = state;
    assign count_next = fifoCount + CW'(push) - CW'(inj);

    inj_fifo #(
        .WIDTH (WIDTH_PORT_NI),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (inj),
        .din   (coreFlit),
        .head  (head),
        .count (fifoCount),
        .full  (full),
        .empty (empty)
    );

    // Starvation FSM state and blocked-cycle counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            blk_cnt <= '0;
        end else begin
            state   <= state_next;
            blk_cnt <= blk_next;
        end
    end

    // Next state: count blocked head cycles (saturating), clear on every injection.
    always_comb begin
        state_next = state;
        blk_next   = blk_cnt;
        case (state)
            ST_IDLE: begin
                blk_next = '0;
                if (push) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (inj) begin
                    blk_next   = '0;
                    state_next = (count_next == '0) ? ST_IDLE : ST_WAIT;
                end else begin
                    if (blk_cnt < LIMIT) blk_next = blk_cnt + BLK_CNT_W'(1);
                    if (blk_next == LIMIT) state_next = ST_STARVED;
                end
            end
            ST_STARVED: begin
                if (inj) begin
                    blk_next   = '0;
                    state_next = (count_next == '0) ? ST_IDLE : ST_WAIT;
                end
            end
            default: begin
                state_next = ST_IDLE;
                blk_next   = '0;
            end
        endcase
    end

    // Injection counter, wraps modulo 2^16.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            injCount <= '0;
        end else if (inj) begin
            injCount <= injCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_bless_inject_ctrl.sv
// Directed bench for bless_inject_ctrl with an in-order injection scoreboard.
module tb_bless_inject_ctrl;
    import bless_inject_ctrl_pkg::*;

    logic                      clk;
    logic                      reset;
    logic [WIDTH_PORT_NI-1:0]  coreFlit;
    logic                      coreValid;
    logic                      coreReady;
    logic [WIDTH_PORT-1:0]     dinW, dinE, dinS, dinN;
    logic [WIDTH_PORT_NI-1:0]  injFlit;
    logic                      starve;
    logic [2:0]                fifoCount;
    logic [15:0]               injCount;
    starve_state_t             fsm_state;

    logic [WIDTH_PORT_NI-1:0]  exp_q[$];
    int                        checks   = 0;
    int                        failures = 0;

    bless_inject_ctrl #(.DEPTH(4), .STARVE_LIMIT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .coreFlit  (coreFlit),
        .coreValid (coreValid),
        .coreReady (coreReady),
        .dinW      (dinW),
        .dinE      (dinE),
        .dinS      (dinS),
        .dinN      (dinN),
        .injFlit   (injFlit),
        .starve    (starve),
        .fifoCount (fifoCount),
        .injCount  (injCount),
        .fsm_state (fsm_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_block(input bit b);
        if (b) begin
            dinW = 16'($urandom_range(1, 16'hFFFF));
            dinE = 16'($urandom_range(1, 16'hFFFF));
            dinS = 16'($urandom_range(1, 16'hFFFF));
            dinN = 16'($urandom_range(1, 16'hFFFF));
        end else begin
            dinW = '0; dinE = '0; dinS = '0; dinN = '0;
        end
    endtask

    task automatic push_flit(input logic [15:0] f, input bit exp_acc);
        coreFlit  = f;
        coreValid = 1'b1;
        #1;
        check("core_ready", {31'd0, coreReady}, {31'd0, exp_acc});
        if (exp_acc && f != 16'd0) exp_q.push_back(f);
        tick();
        coreValid = 1'b0;
        coreFlit  = '0;
    endtask

    // Scoreboard: every nonzero injFlit cycle must match the oldest accepted flit.
    always @(negedge clk) begin
        logic [WIDTH_PORT_NI-1:0] e;
        if (!reset && injFlit !== '0) begin
            if (exp_q.size() == 0) begin
                check("inj_unexpected", {16'd0, injFlit}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("inj_order", {16'd0, injFlit}, {16'd0, e});
            end
        end
    end

    initial begin
        logic [15:0] f;
        reset = 1'b1; coreValid = 1'b0; coreFlit = '0;
        set_block(0);
        #3;
        check("rst_inj", {16'd0, injFlit}, 32'd0);
        check("rst_starve", {31'd0, starve}, 32'd0);
        check("rst_count", {29'd0, fifoCount}, 32'd0);
        check("rst_injcnt", {16'd0, injCount}, 32'd0);
        check("rst_ready", {31'd0, coreReady}, 32'd1);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Single flit, unblocked
        push_flit(16'h00A5, 1);
        check("t1_inj", {16'd0, injFlit}, 32'h00A5);
        tick();
        check("t1_injcnt", {16'd0, injCount}, 32'd1);
        check("t1_count", {29'd0, fifoCount}, 32'd0);
        check("t1_idle", {16'd0, injFlit}, 32'd0);

        // Starvation
        set_block(1);
        push_flit(16'h1111, 1);
        for (int i = 0; i < 15; i++) begin
            check("t2_blocked", {16'd0, injFlit}, 32'd0);
            tick();
        end
        check("t2_starve_pre", {31'd0, starve}, 32'd0);
        tick();
        check("t2_starve_rise", {31'd0, starve}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("t2_blocked2", {16'd0, injFlit}, 32'd0);
            tick();
        end
        check("t2_starve_hold", {31'd0, starve}, 32'd1);
        dinN = '0;
        #1;
        check("t2_inj", {16'd0, injFlit}, 32'h1111);
        check("t2_starve_until_edge", {31'd0, starve}, 32'd1);
        tick();
        check("t2_starve_fall", {31'd0, starve}, 32'd0);
        check("t2_count", {29'd0, fifoCount}, 32'd0);
        check("t2_injcnt", {16'd0, injCount}, 32'd2);

        // Fill to full while blocked, reject fifth, drain in order
        set_block(1);
        for (int i = 1; i <= 4; i++) push_flit(16'h2000 + 16'(i), 1);
        check("t3_ready", {31'd0, coreReady}, 32'd0);
        check("t3_count4", {29'd0, fifoCount}, 32'd4);
        push_flit(16'h2005, 0);
        check("t3_count_rej", {29'd0, fifoCount}, 32'd4);
        set_block(0);
        #1;
        for (int i = 1; i <= 4; i++) begin
            check("t3_drain", {16'd0, injFlit}, {16'd0, 16'h2000 + 16'(i)});
            tick();
        end
        check("t3_count0", {29'd0, fifoCount}, 32'd0);

        // Simultaneous push and pop at count 2
        set_block(1);
        push_flit(16'h3001, 1);
        push_flit(16'h3002, 1);
        check("t4_count2", {29'd0, fifoCount}, 32'd2);
        set_block(0);
        push_flit(16'h3003, 1);
        check("t4_count_same", {29'd0, fifoCount}, 32'd2);
        tick(); tick();
        check("t4_count0", {29'd0, fifoCount}, 32'd0);

        // Pointer wrap: 10 flits through a 4-deep FIFO at occupancy 3
        set_block(1);
        for (int i = 1; i <= 3; i++) push_flit(16'h4000 + 16'(i), 1);
        set_block(0);
        for (int i = 4; i <= 10; i++) push_flit(16'h4000 + 16'(i), 1);
        check("t4_wrap_count", {29'd0, fifoCount}, 32'd3);
        tick(); tick(); tick();
        check("t4_wrap_drained", {29'd0, fifoCount}, 32'd0);

        // All-zero flit is handshaken but dropped
        push_flit(16'h0000, 1);
        check("t5_zero_count", {29'd0, fifoCount}, 32'd0);
        check("t5_zero_inj", {16'd0, injFlit}, 32'd0);
        set_block(1);
        push_flit(16'h5001, 1);
        push_flit(16'h0000, 1);
        check("t5_zero_count1", {29'd0, fifoCount}, 32'd1);
        set_block(0);
        #1;
        check("t5_inj", {16'd0, injFlit}, 32'h5001);
        tick();
        check("t5_count0", {29'd0, fifoCount}, 32'd0);

        // Reset mid-burst with starve high
        set_block(1);
        for (int i = 1; i <= 3; i++) push_flit(16'h6000 + 16'(i), 1);
        check("t6_count3", {29'd0, fifoCount}, 32'd3);
        repeat (14) tick();
        check("t6_starve", {31'd0, starve}, 32'd1);
        reset = 1'b1;
        set_block(0);
        #1;
        exp_q.delete();
        check("t6_rst_inj", {16'd0, injFlit}, 32'd0);
        check("t6_rst_count", {29'd0, fifoCount}, 32'd0);
        check("t6_rst_starve", {31'd0, starve}, 32'd0);
        check("t6_rst_injcnt", {16'd0, injCount}, 32'd0);
        check("t6_rst_ready", {31'd0, coreReady}, 32'd1);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_no_stale", {16'd0, injFlit}, 32'd0);
        end
        check("t6_injcnt", {16'd0, injCount}, 32'd0);

        // injCount wrap at 0xFFFF
        for (int i = 0; i < 65535; i++) begin
            f = 16'(i % 1000) + 16'd1;
            coreFlit  = f;
            coreValid = 1'b1;
            exp_q.push_back(f);
            tick();
        end
        coreValid = 1'b0;
        coreFlit  = '0;
        tick();
        check("t7_injcnt_ffff", {16'd0, injCount}, 32'hFFFF);
        push_flit(16'h7777, 1);
        tick();
        check("t7_injcnt_wrap", {16'd0, injCount}, 32'd0);
        check("t7_count0", {29'd0, fifoCount}, 32'd0);

        // Final report
        check("sb_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bless_inject_ctrl.md
# bless_inject_ctrl

Local-injection scheduler for the bufferless BLESS router. Holds core-generated flits in a small FIFO and drives the router's local input only in cycles when at least one of the four network inputs is empty, so the bufferless router never sees more flits than it has output ports. Tracks consecutive blocked cycles and raises a starvation flag for upstream throttling. Sits between the network interface and the router's `dinLocal` port.

## Interface

- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `STARVE_LIMIT`, 16: blocked cycles before `starve` asserts; range 1..255.
- `clk`  in  1  single clock; all state on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `coreFlit`  in  `WIDTH_PORT_NI`  flit from core, local-port format.
- `coreValid`  in  1  `coreFlit` valid.
- `coreReady`  out  1  FIFO can accept; equals `!full`, registered-state derived.
- `dinW`, `dinE`, `dinS`, `dinN`  in  `WIDTH_PORT` each  same nets feeding the router's network inputs; all-zero means empty.
- `injFlit`  out  `WIDTH_PORT_NI`  to router `dinLocal`; all-zero means no injection.
- `starve`  out  1  head flit blocked for at least `STARVE_LIMIT` consecutive cycles.
- `fifoCount`  out  clog2(DEPTH)+1  current occupancy.
- `injCount`  out  16  flits injected since reset; wraps modulo 2^16.

## Operation

- Push: `coreValid && coreReady` at a posedge writes `coreFlit` to the tail. An all-zero `coreFlit` is accepted and discarded (no enqueue), since zero encodes empty downstream.
- Slot free: `free = (number of nonzero din*) < 4`, combinational.
- Inject: `inj = !empty && free`. When `inj`, `injFlit` = FIFO head; otherwise `injFlit` = 0. The head pops at the posedge ending any cycle with `inj` high.
- Push and pop in the same cycle are allowed whenever not full; occupancy is unchanged. When full, no push, so `coreReady` = 0 and push is blocked even if a pop occurs that cycle.
- Pointers wrap modulo `DEPTH`. Full/empty come from `fifoCount`.
- The starvation FSM runs on head status:
  - IDLE: FIFO empty. Goes to WAIT on a push.
  - WAIT: head present. On `inj`, stays in WAIT, or goes to IDLE if the FIFO empties. On `!inj`, the blocked counter increments; when it reaches `STARVE_LIMIT`, goes to STARVED.
  - STARVED: `starve` = 1. On `inj`, clears the counter and goes to WAIT or IDLE.
- The blocked counter clears on every injection. It saturates at `STARVE_LIMIT` and never wraps.
- `injCount` increments by 1 per injection and wraps from 0xFFFF to 0.
- Flit contents are opaque to this block.

## Timing

- Reset values:
  - `injFlit` = 0, `starve` = 0, `fifoCount` = 0, `injCount` = 0, `coreReady` = 1.
  - FSM = IDLE, counter = 0, pointers = 0.
- `injFlit` is combinational from registered FIFO head and current `din*`. The router registers it on the same edge as `din*`, so no added latency.
- Minimum core-to-injection latency: a flit pushed at edge k appears on `injFlit` in cycle k..k+1 if `free`. An empty FIFO has no bypass.
- `starve` is registered. It rises on the edge at which the counter reaches `STARVE_LIMIT`, i.e. after exactly `STARVE_LIMIT` consecutive blocked cycles with a head present. It falls on the edge after the first injection.
- `coreReady` and `fifoCount` update on the edge after a push or pop.
- Reset asserted mid-operation discards FIFO contents and forces all outputs to reset values asynchronously. `injFlit` goes to 0 regardless of `din*`.

## Structure

- Width macros `WIDTH_PORT` and `WIDTH_PORT_NI` come from the shared `global.v`.
- Add `STARVE_LIMIT_DEFAULT` and `INJ_FIFO_DEPTH` defines there.
- FSM state encodings are localparams in this module.
- One sub-module, `inj_fifo`: parameterised synchronous FIFO with push, pop, head, count and async active-high reset. Starvation FSM, free-slot logic and counters live in `bless_inject_ctrl`.

## Test plan

- Reset, then push one flit 0x00A5 with all `din*` = 0 → `injFlit` = 0x00A5 next cycle; pops; `injCount` = 1; `fifoCount` returns to 0.
- All four `din*` nonzero for 20 cycles with one flit queued, `STARVE_LIMIT` = 16 → `injFlit` = 0 throughout. `starve` rises after the 16th blocked cycle. Clear `dinN` → flit injects that cycle; `starve` drops on the next edge.
- Push 4 flits while blocked (`DEPTH` = 4) → `coreReady` = 0 and `fifoCount` = 4. A 5th `coreValid` is not accepted. Unblock → flits inject in FIFO order on 4 consecutive cycles.
- Simultaneous push and pop at `fifoCount` = 2 → count stays 2 and order is preserved. Wrap test: 10 flits with `DEPTH` = 4 → all emerge in order.
- Push all-zero `coreFlit` → accepted, `fifoCount` unchanged, no injection.
- Assert `reset` mid-burst with 3 flits queued → `injFlit`, `fifoCount`, `starve` = 0 immediately. After release, no stale flit injects. `injCount` at 0xFFFF plus one injection → 0.
